im2col_window_gen: RTL

IM2COL_WINDOW_GEN -- requirements
Module: im2col_window_gen

---
 rtl/im2col_window_gen_if.sv | 34 +++
 rtl/im2col_window_gen.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/im2col_window_gen_if.sv
// Port bundle for im2col_window_gen: job configuration, SRAM read port and window stream.
interface im2col_window_gen_if #(
    parameter int ADR_W  = 16,
    parameter int SRAM_W = 64,
    parameter int K      = 3,
    parameter int DIM_W  = 8
);
    logic                    i_start;
    logic [ADR_W-1:0]        i_base_addr;
    logic [DIM_W-1:0]        i_fm_w;
    logic [DIM_W-1:0]        i_fm_h;
    logic [1:0]              i_stride;
    logic                    i_pad;
    logic [ADR_W-1:0]        o_sram_addr;
    logic                    o_sram_rden;
    logic [SRAM_W-1:0]       i_sram_data;
    logic signed [7:0]       o_win [K*K];
    logic                    o_valid;
    logic                    i_ready;
    logic                    o_busy;
    logic                    o_done;

    modport master (
        input  i_start, i_base_addr, i_fm_w, i_fm_h, i_stride, i_pad,
        input  i_sram_data, i_ready,
        output o_sram_addr, o_sram_rden, o_win, o_valid, o_busy, o_done
    );

    modport slave (
        output i_start, i_base_addr, i_fm_w, i_fm_h, i_stride, i_pad,
        output i_sram_data, i_ready,
        input  o_sram_addr, o_sram_rden, o_win, o_valid, o_busy, o_done
    );
endinterface

// File: rtl/im2col_window_gen.sv
// im2col window generator: walks KxK windows over one 8-bit channel plane in SRAM and streams them.
// Zero padding of K/2 exists only when built with IM2COL_PAD_EN; otherwise i_pad is ignored.
module im2col_window_gen #(
    parameter int ADR_W  = 16,
    parameter int SRAM_W = 64,
    parameter int K      = 3,
    parameter int DIM_W  = 8
) (
    input  logic                i_clk,
    input  logic                i_rstn,
    im2col_window_gen_if.master bus
);
    localparam int PPW     = SRAM_W / 8;
    localparam int LOG_PPW = $clog2(PPW);
    localparam int LW      = (LOG_PPW > 0) ? LOG_PPW : 1;
    localparam int NE      = K * K;
    localparam int EW      = $clog2(NE + 1);
    localparam int KW      = $clog2(K + 1);
    localparam int CW      = DIM_W + 2;
    localparam int HALF    = K / 2;
    localparam logic signed [CW-1:0] K_S = CW'(K);

    typedef enum logic [2:0] {IDLE, FETCH, DRAIN, OUT, DONE} state_t;

    state_t               state_q, state_d;
    logic [ADR_W-1:0]     base_q, base_d;
    logic [DIM_W-1:0]     w_q, w_d, h_q, h_d, wpr_q, wpr_d;
    logic signed [CW-1:0] s_q, s_d, p_q, p_d, r0_q, r0_d, c0_q, c0_d;
    logic [KW-1:0]        kr_q, kr_d, kc_q, kc_d;
    logic [EW-1:0]        elem_q, elem_d;
    logic                 pend_q, pend_d, pend_rd_q, pend_rd_d;
    logic [EW-1:0]        pend_slot_q, pend_slot_d;
    logic [LW-1:0]        pend_lane_q, pend_lane_d;
    logic signed [7:0]    win_q [NE];
    logic signed [7:0]    win_d [NE];

    logic signed [CW-1:0] r_pix, c_pix;
    logic                 in_bounds, rden;
    logic [DIM_W-1:0]     r_u, c_u;
    logic [2*DIM_W-1:0]   row_off;
    logic [7:0]           rd_byte;
    logic [1:0]           p_start;
    logic [DIM_W+1:0]     w_span, h_span;

`ifdef IM2COL_PAD_EN
    assign p_start = bus.i_pad ? 2'(HALF) : 2'd0;
`else
    logic unused_pad;
    assign unused_pad = bus.i_pad;
    assign p_start    = 2'd0;
`endif

    // Padded extent of the incoming job, used to reject maps smaller than the kernel
    assign w_span = (DIM_W+2)'(bus.i_fm_w) + (DIM_W+2)'({p_start, 1'b0});
    assign h_span = (DIM_W+2)'(bus.i_fm_h) + (DIM_W+2)'({p_start, 1'b0});

    always_comb begin
        r_pix     = r0_q + $signed(CW'(kr_q));
        c_pix     = c0_q + $signed(CW'(kc_q));
        in_bounds = !r_pix[CW-1] && (r_pix < $signed(CW'(h_q))) &&
                    !c_pix[CW-1] && (c_pix < $signed(CW'(w_q)));
        rden      = (state_q == FETCH) && in_bounds;
        r_u       = r_pix[DIM_W-1:0];
        c_u       = c_pix[DIM_W-1:0];
        row_off   = (2*DIM_W)'(r_u) * (2*DIM_W)'(wpr_q);
    end

    assign bus.o_sram_rden = rden;
    assign bus.o_sram_addr = rden ? (base_q + ADR_W'(row_off) + ADR_W'(c_u >> LOG_PPW)) : '0;

    always_comb begin
        rd_byte = '0;
        for (int i = 0; i < PPW; i++) begin
            if (pend_lane_q == LW'(i)) rd_byte = bus.i_sram_data[i*8 +: 8];
        end
    end

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        w_d         = w_q;
        h_d         = h_q;
        wpr_d       = wpr_q;
        s_d         = s_q;
        p_d         = p_q;
        r0_d        = r0_q;
        c0_d        = c0_q;
        kr_d        = kr_q;
        kc_d        = kc_q;
        elem_d      = elem_q;
        pend_d      = 1'b0;
        pend_rd_d   = 1'b0;
        pend_slot_d = pend_slot_q;
        pend_lane_d = pend_lane_q;
        win_d       = win_q;

        // Element issued last cycle lands now: SRAM byte if it was read, zero if out of bounds
        if (pend_q) win_d[pend_slot_q] = pend_rd_q ? $signed(rd_byte) : 8'sd0;

        case (state_q)
            IDLE: begin
                if (bus.i_start) begin
                    base_d = bus.i_base_addr;
                    w_d    = bus.i_fm_w;
                    h_d    = bus.i_fm_h;
                    wpr_d  = DIM_W'(((DIM_W+1)'(bus.i_fm_w) + (DIM_W+1)'(PPW - 1)) >> LOG_PPW);
                    s_d    = $signed(CW'(bus.i_stride));
                    p_d    = $signed(CW'(p_start));
                    r0_d   = -$signed(CW'(p_start));
                    c0_d   = -$signed(CW'(p_start));
                    kr_d   = '0;
                    kc_d   = '0;
                    elem_d = '0;
                    state_d = ((w_span < (DIM_W+2)'(K)) || (h_span < (DIM_W+2)'(K))) ? DONE : FETCH;
                end
            end
            FETCH: begin
                pend_d      = 1'b1;
                pend_rd_d   = rden;
                pend_slot_d = elem_q;
                pend_lane_d = LW'(c_u & DIM_W'(PPW - 1));
                if (elem_q == EW'(NE - 1)) begin
                    elem_d  = '0;
                    kr_d    = '0;
                    kc_d    = '0;
                    state_d = DRAIN;
                end else begin
                    elem_d = elem_q + EW'(1);
                    if (kc_q == KW'(K - 1)) begin
                        kc_d = '0;
                        kr_d = kr_q + KW'(1);
                    end else begin
                        kc_d = kc_q + KW'(1);
                    end
                end
            end
            DRAIN: state_d = OUT;
            OUT: begin
                if (bus.i_ready) begin
                    // Row ends when the next window would overhang the padded right edge
                    if (c0_q + s_q + K_S > $signed(CW'(w_q)) + p_q) begin
                        c0_d = -p_q;
                        if (r0_q + s_q + K_S > $signed(CW'(h_q)) + p_q) begin
                            state_d = DONE;
                        end else begin
                            r0_d    = r0_q + s_q;
                            state_d = FETCH;
                        end
                    end else begin
                        c0_d    = c0_q + s_q;
                        state_d = FETCH;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q     <= IDLE;
            base_q      <= '0;
            w_q         <= '0;
            h_q         <= '0;
            wpr_q       <= '0;
            s_q         <= '0;
            p_q         <= '0;
            r0_q        <= '0;
            c0_q        <= '0;
            kr_q        <= '0;
            kc_q        <= '0;
            elem_q      <= '0;
            pend_q      <= 1'b0;
            pend_rd_q   <= 1'b0;
            pend_slot_q <= '0;
            pend_lane_q <= '0;
            win_q       <= '{default: '0};
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            w_q         <= w_d;
            h_q         <= h_d;
            wpr_q       <= wpr_d;
            s_q         <= s_d;
            p_q         <= p_d;
            r0_q        <= r0_d;
            c0_q        <= c0_d;
            kr_q        <= kr_d;
            kc_q        <= kc_d;
            elem_q      <= elem_d;
            pend_q      <= pend_d;
            pend_rd_q   <= pend_rd_d;
            pend_slot_q <= pend_slot_d;
            pend_lane_q <= pend_lane_d;
            win_q       <= win_d;
        end
    end

    assign bus.o_valid = (state_q == OUT);
    assign bus.o_busy  = (state_q != IDLE);
    assign bus.o_done  = (state_q == DONE);

    for (genvar g = 0; g < NE; g++) begin : g_win
        assign bus.o_win[g] = win_q[g];
    end
endmodule
